// File: rtl/spin_pkg.sv
// Shared definitions for the reel spin down-counter: FSM state encoding,
// default parameter values and a helper for sizing the step prescaler.
package spin_pkg;

    // Spin controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } spin_state_t;

    // Default configuration values.
    localparam int DEF_WIDTH        = 10;
    localparam int DEF_PRESCALE     = 4;
    localparam int DEF_DECEL_THRESH = 8;

    // Bits needed to hold prescaler values 0 .. period_max-1 (at least one bit).
    function automatic int psc_width(input int period_max);
        return (period_max <= 2) ? 1 : $clog2(period_max);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step prescaler for the spin down-counter. Counts enabled cycles and
// raises wrap combinationally on the last cycle of a step period, then
// restarts from zero. clear dominates and forces the count back to zero.
module tick_prescaler #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [PW-1:0] period,
    output logic          wrap
);

    logic [PW-1:0] psc_reg;
    logic [PW-1:0] psc_next;

    // Wrap on the final enabled cycle of the current period.
    always_comb begin
        wrap = enable && (psc_reg == (period - PW'(1)));
    end

    // Next prescaler value: clear, restart after a wrap, or advance when enabled.
    always_comb begin
        psc_next = psc_reg;
        if (clear || wrap) begin
            psc_next = '0;
        end else if (enable) begin
            psc_next = psc_reg + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_reg <= '0;
        end else begin
            psc_reg <= psc_next;
        end
    end

endmodule

// File: rtl/spin_down_counter.sv
// Reel spin down-counter. Accepts a step count over a valid/ready load
// handshake, emits one tick per reel step at a prescaled rate and pulses
// done for one cycle when the count reaches zero. abort ends the spin
// without done; pause freezes both the prescaler and the count.
// Optional feature macro: SPIN_DECEL_EN -- doubles the step period while
// the count being decremented is at or below DECEL_THRESH.
module spin_down_counter
    import spin_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int DECEL_THRESH = DEF_DECEL_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    // The decelerated period is twice PRESCALE, which takes one extra bit.
`ifdef SPIN_DECEL_EN
    localparam int PW = psc_width(PRESCALE) + 1;
`else
    localparam int PW = psc_width(PRESCALE);
`endif

    localparam logic [PW-1:0] PERIOD_FAST = PW'(PRESCALE);

    spin_state_t      state_reg;
    spin_state_t      state_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    logic [PW-1:0]    period;
    logic             psc_clear;
    logic             psc_enable;
    logic             wrap;

`ifdef SPIN_DECEL_EN
    localparam logic [PW-1:0] PERIOD_SLOW = PW'(2 * PRESCALE);

    // count only changes on a wrap, so the period picked here stays fixed
    // for the whole step it governs.
    always_comb begin
        period = (int'(count_reg) <= DECEL_THRESH) ? PERIOD_SLOW : PERIOD_FAST;
    end
`else
    // Constant step period.
    always_comb begin
        period = PERIOD_FAST;
    end
`endif

    // Prescaler runs only in RUN, stalls on pause, and is cleared outside
    // RUN or on abort so every spin starts its first step from zero.
    always_comb begin
        psc_enable = (state_reg == RUN) && !pause && !abort;
        psc_clear  = (state_reg != RUN) || abort;
    end

    tick_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (psc_clear),
        .enable (psc_enable),
        .period (period),
        .wrap   (wrap)
    );

    // Next-state and count logic; abort outranks pause, pause outranks tick.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (load_valid) begin
                    count_next = load_value;
                    state_next = (load_value != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    count_next = '0;
                    state_next = IDLE;
                end else if (wrap) begin
                    if (count_reg != '0) begin
                        count_next = count_reg - WIDTH'(1);
                    end
                    if (count_reg == WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                count_next = '0;
                state_next = IDLE;
            end
            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state; tick is the gated wrap.
    always_comb begin
        load_ready = (state_reg == IDLE);
        busy       = (state_reg == RUN);
        done       = (state_reg == DONE);
        tick       = wrap;
        count      = count_reg;
    end

    // State and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_spin_down_counter.sv
// Scoreboard bench for spin_down_counter (WIDTH=10, PRESCALE=4).
// Stimulus pushes hand-computed tick/done events; a negedge monitor pops
// and compares whenever the DUT raises tick or done.
module tb_spin_down_counter;

    localparam int WIDTH        = 10;
    localparam int PRESCALE     = 4;
    localparam int DECEL_THRESH = 1;
    localparam int EV_TICK      = 0;
    localparam int EV_DONE      = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_value = '0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tick;
    logic             done;

    spin_down_counter #(
        .WIDTH        (WIDTH),
        .PRESCALE     (PRESCALE),
        .DECEL_THRESH (DECEL_THRESH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .tick       (tick),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
        int cnt;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cyc %0d)", name, act, cyc);
        end
    endtask

    function automatic void exp_ev(input int kind, input int at, input int cnt);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.cnt  = cnt;
        sb.push_back(e);
    endfunction

    // Monitor: every tick/done cycle is matched against the scoreboard head.
    always @(negedge clk) begin
        if (tick || done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got tick=%0d done=%0d count=%0d at cyc %0d, expected none",
                         tick, done, count, cyc);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("event_kind", tick ? EV_TICK : EV_DONE, e.kind);
                chk("event_cycle", cyc, e.at);
                chk("event_count", int'(count), e.cnt);
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a load and return the cyc value seen during RUN cycle 1.
    task automatic do_load(input logic [WIDTH-1:0] v, output int e0);
        int w = 0;
        while (!load_ready && w < 100) begin
            step();
            w++;
        end
        load_valid = 1'b1;
        load_value = v;
        step();
        e0 = cyc;
        load_valid = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty.
    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            step();
            w++;
        end
        repeat (2) step();
        chk("queue_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int e0;

        // Reset state.
        repeat (3) step();
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", tick, 0);
        chk("rst_load_ready", load_ready, 1);
        step();
        reset = 1'b0;
        step();

`ifndef SPIN_DECEL_EN
        // Basic spin: load 3.
        do_load(10'd3, e0);
        exp_ev(EV_TICK, e0 + 3, 3);
        exp_ev(EV_TICK, e0 + 7, 2);
        exp_ev(EV_TICK, e0 + 11, 1);
        exp_ev(EV_DONE, e0 + 12, 0);
        repeat (4) step();
        @(negedge clk);
        chk("basic_count_c5", int'(count), 2);
        step();
        repeat (8) step();
        @(negedge clk);
        chk("basic_ready_c14", load_ready, 1);
        chk("basic_busy_c14", busy, 0);
        drain();
`endif

        // Zero load: done in cycle 1, never busy.
        do_load(10'd0, e0);
        exp_ev(EV_DONE, e0, 0);
        @(negedge clk);
        chk("zero_busy_c1", busy, 0);
        step();
        @(negedge clk);
        chk("zero_busy_c2", busy, 0);
        chk("zero_ready_c2", load_ready, 1);
        drain();

        // Pause in cycles 2-4.
        do_load(10'd2, e0);
`ifdef SPIN_DECEL_EN
        exp_ev(EV_TICK, e0 + 6, 2);
        exp_ev(EV_TICK, e0 + 14, 1);
        exp_ev(EV_DONE, e0 + 15, 0);
`else
        exp_ev(EV_TICK, e0 + 6, 2);
        exp_ev(EV_TICK, e0 + 10, 1);
        exp_ev(EV_DONE, e0 + 11, 0);
`endif
        step();
        pause = 1'b1;
        step();
        @(negedge clk);
        chk("pause_busy_c3", busy, 1);
        chk("pause_count_c3", int'(count), 2);
        step();
        step();
        pause = 1'b0;
        drain();

        // Abort in cycle 6: one tick, then IDLE with count 0 and no done.
        do_load(10'd5, e0);
        exp_ev(EV_TICK, e0 + 3, 5);
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_count", int'(count), 0);
        chk("abort_ready", load_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        drain();

        // Abort together with pause still aborts.
        do_load(10'd5, e0);
        step();
        abort = 1'b1;
        pause = 1'b1;
        step();
        abort = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        chk("abort_pause_count", int'(count), 0);
        chk("abort_pause_ready", load_ready, 1);
        drain();

        // Reset in cycle 9 of a 10-step spin.
        do_load(10'd10, e0);
        exp_ev(EV_TICK, e0 + 3, 10);
        exp_ev(EV_TICK, e0 + 7, 9);
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_count", int'(count), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_tick", tick, 0);
        chk("midrst_ready", load_ready, 1);
        drain();

        // Load of 1 after the reset.
        do_load(10'd1, e0);
`ifdef SPIN_DECEL_EN
        exp_ev(EV_TICK, e0 + 7, 1);
        exp_ev(EV_DONE, e0 + 8, 0);
`else
        exp_ev(EV_TICK, e0 + 3, 1);
        exp_ev(EV_DONE, e0 + 4, 0);
`endif
        drain();

`ifdef SPIN_DECEL_EN
        // Deceleration with threshold 1: load 2 ticks in cycles 4 and 12.
        do_load(10'd2, e0);
        exp_ev(EV_TICK, e0 + 3, 2);
        exp_ev(EV_TICK, e0 + 11, 1);
        exp_ev(EV_DONE, e0 + 12, 0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spin_down_counter.md
# spin_down_counter

Loadable down-counter that times one reel spin. It accepts a step count over a valid/ready load handshake and emits one `tick` pulse per reel step at a prescaled rate. When the count reaches zero it raises a one-cycle `done`. It is the counterpart to the free-running up `counter`: that block produces a time base, and this block consumes a programmed count down to completion.

## Interface
Parameters:
- `WIDTH`, 10: width of the step count and `load_value`.
- `PRESCALE`, 4: clock cycles per step; legal range 1 to 2^16-1.
- `DECEL_THRESH`, 8: count at or below which deceleration applies. Used only with `SPIN_DECEL_EN`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  a load request is presented.
- `load_ready`  out  1  block can accept a load; high only in IDLE.
- `load_value`  in  WIDTH  number of steps to spin.
- `pause`  in  1  freezes the prescaler and the count while RUN.
- `abort`  in  1  ends the spin immediately, without `done`.
- `count`  out  WIDTH  remaining steps.
- `busy`  out  1  high in RUN.
- `tick`  out  1  one-cycle pulse per step; combinational from registered state and inputs.
- `done`  out  1  one-cycle completion pulse; high in DONE.

## Operation
- Reset values: state IDLE, `count`=0, prescaler=0, `busy`=0, `done`=0, `tick`=0, `load_ready`=1.
- IDLE:
  - `load_ready`=1.
  - On `load_valid`: `count`<=`load_value` and prescaler<=0.
  - Next state is RUN if `load_value`!=0, otherwise DONE.
- RUN:
  - Prescaler increments on each cycle where `pause`=0.
  - `tick` = RUN & !`abort` & !`pause` & (prescaler == period-1).
  - On `tick`: `count`<=`count`-1 and prescaler<=0.
  - A `tick` taken with `count`==1 moves to DONE.
- DONE: lasts one cycle with `done`=1 and `count`=0, then returns to IDLE.
- Priority within RUN: `abort` > `pause` > tick.
  - `abort` sets `count`<=0 and prescaler<=0 and returns to IDLE; no `done`, no `tick`.
  - `abort` and `pause` are ignored in IDLE and DONE.
- `load_valid` is ignored outside IDLE. No queueing; the requester holds `load_valid` until it sees `load_ready`.
- `count` never underflows; decrement happens only from a nonzero value.
- `reset` asserted mid-spin returns every output to its reset value at the next edge.

## Timing
- Load is accepted at edge E0. Count the first RUN cycle as cycle 1.
- Without deceleration:
  - `tick` is high in cycles PRESCALE, 2·PRESCALE, …, N·PRESCALE.
  - `done` is high in cycle N·PRESCALE+1.
  - `load_ready` is high in cycle N·PRESCALE+2.
- Load with `load_value`=0: `done` is high in the cycle immediately after E0, and IDLE follows.
- Each paused cycle delays every later event by exactly one cycle.
- `count` shows the decremented value in the cycle after each `tick`.

## Configuration
- Macro: `SPIN_DECEL_EN`.
- Defined:
  - Step period is 2·PRESCALE whenever the `count` being decremented is ≤ `DECEL_THRESH`, otherwise PRESCALE.
  - The period is chosen at the start of each step and does not change mid-step.
  - The prescaler is one bit wider than it would otherwise need to be.
- Undefined: the period is always PRESCALE and `DECEL_THRESH` is unused.

## Structure
- Shared package `spin_pkg`:
  - State typedef (IDLE, RUN, DONE).
  - Default constants for WIDTH, PRESCALE and DECEL_THRESH.
- Sub-module `tick_prescaler`:
  - Inputs: `clk`, `reset`, `clear`, `enable`, `period`.
  - Output: `wrap`.
  - Holds the prescaler register; the top level owns the FSM and `count`.

## Test plan
All scenarios use WIDTH=10, PRESCALE=4.
- Basic spin: load 3 at E0 → `tick` in cycles 4, 8, 12; `count` goes 3→2→1→0; `done` in cycle 13; `load_ready`=1 in cycle 14.
- Zero load: load 0 → no `tick`; `done` in cycle 1; `busy` never high.
- Pause: load 2, then `pause` in cycles 2–4 → ticks move to cycles 7 and 11; `done` in cycle 12.
- Abort: load 5, then `abort` in cycle 6 → `count`=0 and IDLE next cycle; no `done`. `abort` together with `pause` in the same cycle still aborts.
- Reset mid-spin: load 10, then `reset` in cycle 9 → all outputs at reset values next cycle; a later load of 1 gives `done` in cycle 5.
- `SPIN_DECEL_EN` with `DECEL_THRESH`=1: load 2 → ticks in cycles 4 and 12; `done` in cycle 13.
